// File: rtl/delay_core.sv
// delay_core: per-sample ADC -> SPI SRAM ring buffer -> DAC sequencer
module delay_core #(
    parameter int          ADC_NSCK         = 16,
    parameter int          ADC_CS_LEN       = 66,
    parameter int          DAC_NSCK         = 24,
    parameter int          DAC_CS_LEN       = 2,
    parameter int          RAM_NSCK         = 48,
    parameter int          RAM_CS_LEN       = 2,
    parameter logic [23:0] RAM_END_ADDR     = 24'h01FFFF,
    parameter logic [23:0] W_PTR_START_ADDR = 24'h000000,
    parameter logic [23:0] R_PTR_START_ADDR = 24'h01001C
) (
    input  logic clk,
    input  logic nrst,
    input  logic step,
    output logic sck_adc,
    output logic cnv_adc,
    input  logic sdi_adc,
    output logic sck_dac,
    output logic syn_dac,
    output logic sdo_dac,
    output logic sck_ram,
    output logic css_ram,
    input  logic sdi_ram,
    output logic sdo_ram
);
    typedef enum logic [3:0] {
        IDLE, ADC_CNV, ADC_SHIFT, RAM_WR, RAM_WR_GAP, RAM_RD, RAM_RD_GAP, DAC_SHIFT, DAC_GAP
    } state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] L_CNV    = CW'(ADC_CS_LEN - 1);
    localparam logic [CW-1:0] L_ADC    = CW'(2 * ADC_NSCK - 1);
    localparam logic [CW-1:0] L_RAM    = CW'(2 * RAM_NSCK - 1);
    localparam logic [CW-1:0] L_RGAP   = CW'(RAM_CS_LEN - 1);
    localparam logic [CW-1:0] L_DAC    = CW'(2 * DAC_NSCK - 1);
    localparam logic [CW-1:0] L_DGAP   = CW'(DAC_CS_LEN - 1);
    localparam logic [CW-1:0] RD_FIRST = CW'(2 * (RAM_NSCK - 16));

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, last_cnt;
    logic                  last, step_edge;
    logic                  step_q, step_d, step_r_q, step_r_d;
    logic [15:0]           adc_q, adc_d, dout_q, dout_d;
    logic [23:0]           wp_q, wp_d, rp_q, rp_d;
    logic [RAM_NSCK-1:0]   ram_sr_q, ram_sr_d;
    logic [DAC_NSCK-1:0]   dac_sr_q, dac_sr_d;
    logic                  cnv_adc_q, cnv_adc_d, sck_adc_q, sck_adc_d;
    logic                  css_ram_q, css_ram_d, sck_ram_q, sck_ram_d, sdo_ram_q, sdo_ram_d;
    logic                  syn_dac_q, syn_dac_d, sck_dac_q, sck_dac_d, sdo_dac_q, sdo_dac_d;

    // 16-bit samples occupy two bytes; anything past the last full slot wraps to 0
    function automatic logic [23:0] adv(input logic [23:0] p);
        return (p >= RAM_END_ADDR - 24'd1) ? 24'd0 : p + 24'd2;
    endfunction

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: each non-idle state lasts until its cycle counter hits its length
    always_comb begin
        last_cnt  = (state_q == ADC_CNV) ? L_CNV :
                    (state_q == ADC_SHIFT) ? L_ADC :
                    (state_q == RAM_WR || state_q == RAM_RD) ? L_RAM :
                    (state_q == RAM_WR_GAP || state_q == RAM_RD_GAP) ? L_RGAP :
                    (state_q == DAC_SHIFT) ? L_DAC : L_DGAP;
        last      = cnt_q == last_cnt;
        step_edge = step_q & ~step_r_q;
        state_d   = state_q;
        case (state_q)
            IDLE:       if (step_edge) state_d = ADC_CNV;
            ADC_CNV:    if (last) state_d = ADC_SHIFT;
            ADC_SHIFT:  if (last) state_d = RAM_WR;
            RAM_WR:     if (last) state_d = RAM_WR_GAP;
            RAM_WR_GAP: if (last) state_d = RAM_RD;
            RAM_RD:     if (last) state_d = RAM_RD_GAP;
            RAM_RD_GAP: if (last) state_d = DAC_SHIFT;
            DAC_SHIFT:  if (last) state_d = DAC_GAP;
            DAC_GAP:    if (last) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath: counter, sample capture on rising sck, frame shifters advance on the high phase
    always_comb begin
        step_d   = step;
        step_r_d = step_q;
        cnt_d    = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CW'(1);
        adc_d    = (state_q == ADC_SHIFT && !cnt_q[0]) ? {adc_q[14:0], sdi_adc} : adc_q;
        dout_d   = (state_q == RAM_RD && !cnt_q[0] && cnt_q >= RD_FIRST) ? {dout_q[14:0], sdi_ram} : dout_q;
        ram_sr_d = (state_d == RAM_WR && state_q != RAM_WR) ? {8'h02, wp_q, adc_q} :
                   (state_d == RAM_RD && state_q != RAM_RD) ? {8'h03, rp_q, 16'h0000} :
                   ((state_q == RAM_WR || state_q == RAM_RD) && cnt_q[0]) ? ram_sr_q << 1 : ram_sr_q;
        dac_sr_d = (state_d == DAC_SHIFT && state_q != DAC_SHIFT) ? {8'h00, dout_q} :
                   (state_q == DAC_SHIFT && cnt_q[0]) ? dac_sr_q << 1 : dac_sr_q;
        wp_d     = (state_q == RAM_RD_GAP && last) ? adv(wp_q) : wp_q;
        rp_d     = (state_q == RAM_RD_GAP && last) ? adv(rp_q) : rp_q;
    end

    // Output decode from next state so every pin is a flop aligned with its state
    always_comb begin
        cnv_adc_d = state_d == ADC_CNV;
        sck_adc_d = state_d == ADC_SHIFT && cnt_d[0];
        css_ram_d = !(state_d == RAM_WR || state_d == RAM_RD);
        sck_ram_d = !css_ram_d && cnt_d[0];
        sdo_ram_d = !css_ram_d && ram_sr_d[RAM_NSCK-1];
        syn_dac_d = state_d != DAC_SHIFT;
        sck_dac_d = !syn_dac_d && cnt_d[0];
        sdo_dac_d = !syn_dac_d && dac_sr_d[DAC_NSCK-1];
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            step_q    <= 1'b0;
            step_r_q  <= 1'b0;
            cnt_q     <= '0;
            adc_q     <= '0;
            dout_q    <= '0;
            ram_sr_q  <= '0;
            dac_sr_q  <= '0;
            wp_q      <= W_PTR_START_ADDR;
            rp_q      <= R_PTR_START_ADDR;
            cnv_adc_q <= 1'b0;
            sck_adc_q <= 1'b0;
            css_ram_q <= 1'b1;
            sck_ram_q <= 1'b0;
            sdo_ram_q <= 1'b0;
            syn_dac_q <= 1'b1;
            sck_dac_q <= 1'b0;
            sdo_dac_q <= 1'b0;
        end else begin
            step_q    <= step_d;
            step_r_q  <= step_r_d;
            cnt_q     <= cnt_d;
            adc_q     <= adc_d;
            dout_q    <= dout_d;
            ram_sr_q  <= ram_sr_d;
            dac_sr_q  <= dac_sr_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnv_adc_q <= cnv_adc_d;
            sck_adc_q <= sck_adc_d;
            css_ram_q <= css_ram_d;
            sck_ram_q <= sck_ram_d;
            sdo_ram_q <= sdo_ram_d;
            syn_dac_q <= syn_dac_d;
            sck_dac_q <= sck_dac_d;
            sdo_dac_q <= sdo_dac_d;
        end
    end

    assign cnv_adc = cnv_adc_q;
    assign sck_adc = sck_adc_q;
    assign css_ram = css_ram_q;
    assign sck_ram = sck_ram_q;
    assign sdo_ram = sdo_ram_q;
    assign syn_dac = syn_dac_q;
    assign sck_dac = sck_dac_q;
    assign sdo_dac = sdo_dac_q;
endmodule

// File: tb/tb_delay_core.sv
// tb_delay_core: plays ADC/SRAM/DAC slaves and scoreboards the frames delay_core produces
module tb_delay_core;
    localparam logic [23:0] END_ADDR = 24'h01FFFF;
    localparam int          SEQ_TO_SYN = 66 + 32 + 96 + 2 + 96 + 2 + 48;

    logic clk = 0, nrst_a = 0, nrst_b = 0, step = 0, sdi_adc = 0, sdi_ram = 0;
    int   sel = 0;
    logic [1:0] sck_adc, cnv_adc, sck_dac, syn_dac, sdo_dac, sck_ram, css_ram, sdo_ram;
    logic m_cnv, m_sck_adc, m_sck_dac, m_syn, m_sdo_dac, m_sck_ram, m_css, m_sdo_ram;

    int n_asrt = 0, n_fail = 0;
    logic [47:0] ram_q[$];
    logic [23:0] dac_q[$];
    logic [23:0] wp, rp;
    logic [15:0] adc_word = 0, rd_word = 0;
    bit abort_pend = 0;

    always #5 clk = ~clk;

    delay_core dut_a (
        .clk(clk), .nrst(nrst_a), .step(step),
        .sck_adc(sck_adc[0]), .cnv_adc(cnv_adc[0]), .sdi_adc(sdi_adc),
        .sck_dac(sck_dac[0]), .syn_dac(syn_dac[0]), .sdo_dac(sdo_dac[0]),
        .sck_ram(sck_ram[0]), .css_ram(css_ram[0]), .sdi_ram(sdi_ram), .sdo_ram(sdo_ram[0])
    );

    delay_core #(.W_PTR_START_ADDR(24'h01FFFE), .R_PTR_START_ADDR(24'h01FFFC)) dut_b (
        .clk(clk), .nrst(nrst_b), .step(step),
        .sck_adc(sck_adc[1]), .cnv_adc(cnv_adc[1]), .sdi_adc(sdi_adc),
        .sck_dac(sck_dac[1]), .syn_dac(syn_dac[1]), .sdo_dac(sdo_dac[1]),
        .sck_ram(sck_ram[1]), .css_ram(css_ram[1]), .sdi_ram(sdi_ram), .sdo_ram(sdo_ram[1])
    );

    assign m_cnv     = cnv_adc[sel];
    assign m_sck_adc = sck_adc[sel];
    assign m_sck_dac = sck_dac[sel];
    assign m_syn     = syn_dac[sel];
    assign m_sdo_dac = sdo_dac[sel];
    assign m_sck_ram = sck_ram[sel];
    assign m_css     = css_ram[sel];
    assign m_sdo_ram = sdo_ram[sel];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] next_ptr(input logic [23:0] p);
        return (p + 24'd2 > END_ADDR) ? 24'd0 : p + 24'd2;
    endfunction

    // Slave devices and frame monitor, all sampled on the falling clk edge
    int cyc = 0, t0 = 0, na = 0, nb = 0, nd = 0;
    logic [47:0] fr = 0;
    logic [23:0] dfr = 0;
    logic [7:0]  cmd = 0;
    logic p_cnv = 0, p_sck_adc = 0, p_sck_ram = 0, p_css = 1, p_sck_dac = 0, p_syn = 1;

    always @(negedge clk) begin
        cyc++;
        chk("one_select", m_css | m_syn, 1);
        chk("sck_ram_gated", m_sck_ram & m_css, 0);
        chk("sck_dac_gated", m_sck_dac & m_syn, 0);
        chk("sck_adc_gated", m_sck_adc & m_cnv, 0);
        if (m_cnv && !p_cnv) t0 = cyc;
        if (!m_cnv && p_cnv) begin
            chk("cnv_len", cyc - t0, 66);
            na = 0;
            sdi_adc = adc_word[15];
        end
        if (m_sck_adc && !p_sck_adc) na++;
        if (!m_sck_adc && p_sck_adc && na < 16) sdi_adc = adc_word[15-na];
        if (!m_css && p_css) begin
            nb = 0;
            cmd = 0;
        end
        if (m_sck_ram && !p_sck_ram && !m_css) begin
            fr = {fr[46:0], m_sdo_ram};
            nb++;
            if (nb == 8) cmd = fr[7:0];
        end
        if (!m_sck_ram && p_sck_ram && cmd == 8'h03 && nb >= 32 && nb < 48) sdi_ram = rd_word[47-nb];
        if (m_css && !p_css) begin
            if (abort_pend) abort_pend = 0;
            else if (ram_q.size() == 0) chk("ram_unexpected", fr, 0);
            else begin
                chk("ram_bits", nb, 48);
                chk("ram_frame", fr, ram_q.pop_front());
            end
        end
        if (!m_syn && p_syn) nd = 0;
        if (m_sck_dac && !p_sck_dac && !m_syn) begin
            dfr = {dfr[22:0], m_sdo_dac};
            nd++;
        end
        if (m_syn && !p_syn) begin
            chk("seq_len", cyc - t0, SEQ_TO_SYN);
            chk("adc_pulses", na, 16);
            chk("dac_bits", nd, 24);
            if (dac_q.size() == 0) chk("dac_unexpected", dfr, 0);
            else chk("dac_frame", dfr, dac_q.pop_front());
        end
        p_cnv = m_cnv; p_sck_adc = m_sck_adc; p_sck_ram = m_sck_ram;
        p_css = m_css; p_sck_dac = m_sck_dac; p_syn = m_syn;
    end

    task automatic run_seq(input logic [15:0] aw, input logic [15:0] rw, input bit hold);
        adc_word = aw;
        rd_word = rw;
        ram_q.push_back({8'h02, wp, aw});
        ram_q.push_back({8'h03, rp, 16'h0000});
        dac_q.push_back({8'h00, rw});
        wp = next_ptr(wp);
        rp = next_ptr(rp);
        @(posedge clk); #1 step = 1;
        repeat (3) @(posedge clk); #1 step = hold;
        repeat (100) @(posedge clk); #1 step = 1;
        repeat (3) @(posedge clk); #1 step = hold;
        repeat (300) @(posedge clk); #1 step = 0;
        repeat (5) @(posedge clk);
    endtask

    task automatic abort_seq();
        adc_word = 16'($urandom);
        @(posedge clk); #1 step = 1;
        repeat (3) @(posedge clk); #1 step = 0;
        for (int i = 0; i < 300 && m_css; i++) @(posedge clk);
        chk("abort_reached_wr", m_css, 0);
        repeat (20) @(posedge clk);
        #1 abort_pend = 1;
        nrst_a = 0;
        #1 chk("abort_css", m_css, 1);
        chk("abort_sck_ram", m_sck_ram, 0);
        chk("abort_sdo_ram", m_sdo_ram, 0);
        repeat (3) @(posedge clk);
        #1 nrst_a = 1;
        wp = 24'h000000;
        rp = 24'h01001C;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 chk("rst_syn", m_syn, 1);
        chk("rst_css", m_css, 1);
        chk("rst_cnv", m_cnv, 0);
        chk("rst_scks", {m_sck_adc, m_sck_ram, m_sck_dac}, 0);
        chk("rst_sdos", {m_sdo_ram, m_sdo_dac}, 0);
        nrst_a = 1;
        repeat (5) @(posedge clk);
        wp = 24'h000000;
        rp = 24'h01001C;
        run_seq(16'hFFFF, 16'hFFFF, 0);
        run_seq(16'($urandom), 16'($urandom), 0);
        run_seq(16'($urandom), 16'($urandom), 1);
        run_seq(16'($urandom), 16'($urandom), 0);
        abort_seq();
        run_seq(16'($urandom), 16'($urandom), 0);
        sel = 1;
        #1 nrst_b = 1;
        repeat (5) @(posedge clk);
        wp = 24'h01FFFE;
        rp = 24'h01FFFC;
        for (int i = 0; i < 3; i++) run_seq(16'($urandom), 16'($urandom), 0);
        repeat (20) @(posedge clk);
        chk("ram_q_drained", ram_q.size(), 0);
        chk("dac_q_drained", dac_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/delay_core.md
# delay_core

Sample-rate sequencer at the heart of the delay pedal. On each `step` request it converts one audio sample through an SPI ADC, writes that sample into an external SPI SRAM ring buffer, reads back the sample stored one delay-length earlier, and sends it to an SPI DAC. It sits between the sample-rate timer (drives `step`) and the three off-chip converters/memory; all serial clocks are generated internally from `clk`.

## Interface
- `ADC_NSCK`, 16: ADC serial clocks per frame (sample width).
- `ADC_CS_LEN`, 66: clk cycles `cnv_adc` is held high (conversion time).
- `DAC_NSCK`, 24: DAC frame length in bits (8 control + 16 data).
- `DAC_CS_LEN`, 2: clk cycles `syn_dac` is held high after a DAC frame.
- `RAM_NSCK`, 48: RAM frame length in bits (8 cmd + 24 addr + 16 data).
- `RAM_CS_LEN`, 2: clk cycles `css_ram` is held high after each RAM frame.
- `RAM_END_ADDR`, 24'h01FFFF: last byte address of the ring buffer.
- `W_PTR_START_ADDR`, 24'h000000: write pointer reset value.
- `R_PTR_START_ADDR`, 24'h01001C: read pointer reset value (sets delay length).

Ports:
- `clk` in 1: system clock; the only clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `step` in 1: start one sample cycle (rising-edge detected).
- `sck_adc` out 1: ADC serial clock.
- `cnv_adc` out 1: ADC convert strobe.
- `sdi_adc` in 1: ADC serial data (into core).
- `sck_dac` out 1: DAC serial clock.
- `syn_dac` out 1: DAC frame sync, active-low.
- `sdo_dac` out 1: DAC serial data.
- `sck_ram` out 1: SRAM serial clock.
- `css_ram` out 1: SRAM chip select, active-low.
- `sdi_ram` in 1: SRAM MISO (into core).
- `sdo_ram` out 1: SRAM MOSI.

## Operation
- Reset: state IDLE; `cnv_adc`=0, all `sck_*`=0, `syn_dac`=1, `css_ram`=1, `sdo_dac`=0, `sdo_ram`=0; write ptr = `W_PTR_START_ADDR`, read ptr = `R_PTR_START_ADDR`, sample registers = 0.
- `step` is registered; a 0→1 transition seen in IDLE starts a sequence. Edges during a sequence are ignored (no queuing).
- States, in order: IDLE → ADC_CNV → ADC_SHIFT → RAM_WR → RAM_WR_GAP → RAM_RD → RAM_RD_GAP → DAC_SHIFT → DAC_GAP → IDLE.
- ADC_CNV: `cnv_adc`=1 for `ADC_CS_LEN` cycles. ADC_SHIFT: `cnv_adc`=0, `ADC_NSCK` sck pulses; `sdi_adc` sampled on each `sck_adc` rising edge, MSB first, into 16-bit input sample.
- RAM_WR: `css_ram`=0; shift out cmd 8'h02, write ptr (24 bits), input sample (16 bits), MSB first. Then `css_ram`=1 for `RAM_CS_LEN` cycles.
- RAM_RD: `css_ram`=0; shift out cmd 8'h03, read ptr; during the last 16 clocks `sdo_ram`=0 and `sdi_ram` is sampled on rising `sck_ram` edges, MSB first, into the output sample. Then `css_ram`=1 for `RAM_CS_LEN` cycles.
- DAC_SHIFT: `syn_dac`=0; shift out 8'h00 then output sample, MSB first. DAC_GAP: `syn_dac`=1 for `DAC_CS_LEN` cycles.
- After RAM_RD_GAP both pointers advance by 2 (16-bit samples); a pointer equal to `RAM_END_ADDR`-1 or above wraps to 0. Pointers advance independently; their difference is preserved.

## Timing
- Every serial clock = clk/2: per bit, one cycle low (data driven/changed) then one cycle high (data sampled by receiver at rising edge). Serial clocks idle low; `sck_*` only toggle in their own shift state.
- Output data changes only while the corresponding `sck` is low; the first bit is valid on the cycle the select/sync goes low.
- Cycles per sequence with defaults: 66 + 32 + 96 + 2 + 96 + 2 + 48 + 2 = 344 clk cycles, start counted from the first clk after the registered `step` edge.
- Only one device select is active at a time; `css_ram` and `syn_dac` never low together.
- `nrst` low mid-sequence aborts immediately to reset values; the SRAM write in flight is discarded.

## Test plan
- Reset: hold `nrst`=0 → `syn_dac`=1, `css_ram`=1, `cnv_adc`=0, all sck=0.
- `sdi_adc`=1, `sdi_ram`=1, one `step` pulse → `cnv_adc` high 66 cycles, 16 `sck_adc` pulses; RAM write frame 0x02,0x000000,0xFFFF; read frame 0x03,0x01001C; DAC frame 0x00FFFF; back in IDLE 344 cycles after start.
- Second `step` ~530 cycles later → write address 0x000002, read address 0x01001E.
- `step` held high or pulsed again mid-sequence → no extra or restarted sequence.
- Preload pointers near end (write ptr 0x01FFFE) → next write address 0x000000.
- `nrst` pulsed low during RAM_WR → `css_ram`=1 immediately, pointers return to start values.
